// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle STEP-bit shifter with valid/ready on both sides.
// Define SHIFT_SEQUENCER_ARITH_EN to add up_arith (sign-filling right shifts).
module shift_sequencer #(
  parameter int N    = 8,
  parameter int STEP = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [N-1:0]         up_data,
  input  logic [$clog2(N)-1:0] up_shamt,
  input  logic                 up_dir,
`ifdef SHIFT_SEQUENCER_ARITH_EN
  input  logic                 up_arith,
`endif
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [N-1:0]         down_data,
  output logic                 busy
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   data;
  logic [N-1:0]   data_nx;
  logic [W-1:0]   rem;
  logic [W-1:0]   rem_nx;
  logic [W-1:0]   k;
  logic           dir;
  logic           dir_nx;
  logic [N-1:0]   shl;
  logic [N-1:0]   shr;
  logic [N-1:0]   shr_f;

  always_comb begin
    k   = (32'(rem) > STEP) ? W'(STEP) : rem;
    shl = data << k;
    shr = data >> k;
  end

`ifdef SHIFT_SEQUENCER_ARITH_EN
  // fill is the accepted word's sign bit, gated by up_arith at accept
  logic         fill;
  logic         fill_nx;
  logic [N-1:0] mask;

  always_comb begin
    mask  = ~({N{1'b1}} >> k);
    shr_f = fill ? (shr | mask) : shr;
  end
`else
  always_comb begin
    shr_f = shr;
  end
`endif

  always_comb begin
    state_nx = state;
    data_nx  = data;
    rem_nx   = rem;
    dir_nx   = dir;
`ifdef SHIFT_SEQUENCER_ARITH_EN
    fill_nx  = fill;
`endif
    unique case (state)
      IDLE: begin
        if (up_valid) begin
          data_nx  = up_data;
          rem_nx   = up_shamt;
          dir_nx   = up_dir;
`ifdef SHIFT_SEQUENCER_ARITH_EN
          fill_nx  = up_arith & up_data[N-1];
`endif
          state_nx = (up_shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_nx = dir ? shr_f : shl;
        rem_nx  = rem - k;
        if (rem == k) state_nx = DONE;
      end
      DONE: begin
        if (down_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      rem   <= '0;
      dir   <= 1'b0;
`ifdef SHIFT_SEQUENCER_ARITH_EN
      fill  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      data  <= data_nx;
      rem   <= rem_nx;
      dir   <= dir_nx;
`ifdef SHIFT_SEQUENCER_ARITH_EN
      fill  <= fill_nx;
`endif
    end
  end

  assign up_ready   = (state == IDLE);
  assign down_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign down_data  = data;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of the shift_sequencer handshake,
// latency, stall, reset abort and (when enabled) arithmetic right shift.
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] up_data;
  logic [2:0] up_shamt;
  logic       up_dir;
  logic       up_arith;
  logic       down_valid;
  logic       down_ready;
  logic [7:0] down_data;
  logic       busy;

  int total;
  int bad;

  shift_sequencer #(
    .N(8),
    .STEP(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .up_data(up_data),
    .up_shamt(up_shamt),
    .up_dir(up_dir),
`ifdef SHIFT_SEQUENCER_ARITH_EN
    .up_arith(up_arith),
`endif
    .down_valid(down_valid),
    .down_ready(down_ready),
    .down_data(down_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] s,
                      input logic dr, input logic ar);
    up_valid = 1'b1;
    up_data  = d;
    up_shamt = s;
    up_dir   = dr;
    up_arith = ar;
    tick();
    up_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 ||
        down_data !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b dv=%b dd=%h busy=%b want 1 0 00 0",
               up_ready, down_valid, down_data, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (up_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: rdy=%b busy=%b want 1 0", up_ready, busy);
    end
  endtask

  task automatic test_left3();
    down_ready = 1'b1;
    send(8'hB5, 3'd3, 1'b0, 1'b0);
    up_dir = 1'b1;
    total++;
    if (busy !== 1'b1 || up_ready !== 1'b0 || down_valid !== 1'b0) begin
      bad++;
      $display("FAIL left3_c1: busy=%b rdy=%b dv=%b want 1 0 0",
               busy, up_ready, down_valid);
    end
    tick();
    total++;
    if (down_valid !== 1'b0 || down_data !== 8'hD4) begin
      bad++;
      $display("FAIL left3_c2: dv=%b dd=%h want 0 d4", down_valid, down_data);
    end
    tick();
    total++;
    if (down_valid !== 1'b1 || down_data !== 8'hA8 || up_ready !== 1'b0) begin
      bad++;
      $display("FAIL left3_c3: dv=%b dd=%h rdy=%b want 1 a8 0",
               down_valid, down_data, up_ready);
    end
    tick();
    total++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL left3_c4: rdy=%b dv=%b busy=%b want 1 0 0",
               up_ready, down_valid, busy);
    end
  endtask

  task automatic test_zero_shamt();
    down_ready = 1'b1;
    send(8'hB5, 3'd0, 1'b1, 1'b0);
    total++;
    if (down_valid !== 1'b1 || down_data !== 8'hB5 || busy !== 1'b1) begin
      bad++;
      $display("FAIL zero_c1: dv=%b dd=%h busy=%b want 1 b5 1",
               down_valid, down_data, busy);
    end
    tick();
    total++;
    if (busy !== 1'b0 || up_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_c2: busy=%b rdy=%b want 0 1", busy, up_ready);
    end
  endtask

  task automatic test_right7();
    int n;
    down_ready = 1'b1;
    send(8'h80, 3'd7, 1'b1, 1'b0);
    n = 1;
    while (!down_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 5 || down_data !== 8'h01) begin
      bad++;
      $display("FAIL right7: cycle=%0d dd=%h want 5 01", n, down_data);
    end
    tick();
  endtask

  task automatic test_stall();
    down_ready = 1'b0;
    send(8'hB5, 3'd3, 1'b0, 1'b0);
    tick();
    tick();
    up_valid = 1'b1;
    up_data  = 8'h0F;
    up_shamt = 3'd1;
    up_dir   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (down_valid !== 1'b1 || down_data !== 8'hA8 || up_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_%0d: dv=%b dd=%h rdy=%b want 1 a8 0",
                 i, down_valid, down_data, up_ready);
      end
      tick();
    end
    down_ready = 1'b1;
    total++;
    if (up_ready !== 1'b0 || down_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_hs: rdy=%b dv=%b want 0 1", up_ready, down_valid);
    end
    tick();
    total++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_idle: rdy=%b dv=%b want 1 0", up_ready, down_valid);
    end
    tick();
    up_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || up_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_reaccept: busy=%b rdy=%b want 1 0", busy, up_ready);
    end
    tick();
    total++;
    if (down_valid !== 1'b1 || down_data !== 8'h1E) begin
      bad++;
      $display("FAIL stall_second: dv=%b dd=%h want 1 1e", down_valid, down_data);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    down_ready = 1'b1;
    up_valid = 1'b1;
    up_data  = 8'h3C;
    up_shamt = 3'd2;
    up_dir   = 1'b1;
    tick();
    up_data  = 8'h01;
    up_shamt = 3'd7;
    up_dir   = 1'b0;
    tick();
    total++;
    if (down_valid !== 1'b1 || down_data !== 8'h0F) begin
      bad++;
      $display("FAIL b2b_first: dv=%b dd=%h want 1 0f", down_valid, down_data);
    end
    tick();
    total++;
    if (up_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_idle: rdy=%b want 1", up_ready);
    end
    tick();
    up_valid = 1'b0;
    n = 1;
    while (!down_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n !== 5 || down_data !== 8'h80) begin
      bad++;
      $display("FAIL b2b_second: cycle=%0d dd=%h want 5 80", n, down_data);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    down_ready = 1'b1;
    send(8'h80, 3'd7, 1'b1, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 ||
        down_data !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort: rdy=%b dv=%b dd=%h busy=%b want 1 0 00 0",
               up_ready, down_valid, down_data, busy);
    end
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (down_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_noresult: dv_cycles=%0d want 0", seen);
    end
  endtask

`ifdef SHIFT_SEQUENCER_ARITH_EN
  task automatic test_arith();
    down_ready = 1'b1;
    send(8'h90, 3'd2, 1'b1, 1'b1);
    tick();
    total++;
    if (down_valid !== 1'b1 || down_data !== 8'hE4) begin
      bad++;
      $display("FAIL arith_sra: dv=%b dd=%h want 1 e4", down_valid, down_data);
    end
    tick();
    send(8'h90, 3'd2, 1'b1, 1'b0);
    tick();
    total++;
    if (down_valid !== 1'b1 || down_data !== 8'h24) begin
      bad++;
      $display("FAIL arith_srl: dv=%b dd=%h want 1 24", down_valid, down_data);
    end
    tick();
    send(8'h90, 3'd2, 1'b0, 1'b1);
    tick();
    total++;
    if (down_valid !== 1'b1 || down_data !== 8'h40) begin
      bad++;
      $display("FAIL arith_sll: dv=%b dd=%h want 1 40", down_valid, down_data);
    end
    tick();
  endtask
`endif

  initial begin
    total      = 0;
    bad        = 0;
    up_valid   = 1'b0;
    up_data    = 8'h00;
    up_shamt   = 3'd0;
    up_dir     = 1'b0;
    up_arith   = 1'b0;
    down_ready = 1'b0;
    test_reset();
    test_left3();
    test_zero_shamt();
    test_right7();
    test_stall();
    test_back_to_back();
    test_reset_abort();
`ifdef SHIFT_SEQUENCER_ARITH_EN
    test_arith();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
